// File: rtl/dem_gio_bcd_pkg.sv
// Shared constants and the 24 h -> 12 h display mapping for the dem_gio_bcd time-of-day counter.
package dem_gio_bcd_pkg;

   localparam logic [7:0] BCD_SEC_MAX  = 8'h59;
   localparam logic [7:0] BCD_MIN_MAX  = 8'h59;
   localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
   localparam logic [7:0] BCD_12       = 8'h12;

   typedef struct packed {
      logic       pm;
      logic [7:0] hour;
   } hour12_t;

   // Internal 00-23 maps to 12,01..11 with pm set for 12-23.
   function automatic hour12_t to_12h(input logic [7:0] h24);
      hour12_t    res;
      logic [4:0] bin;
      logic [4:0] rem;
      bin    = 5'(h24[7:4]) * 5'd10 + 5'(h24[3:0]);
      res.pm = (bin >= 5'd12);
      rem    = res.pm ? bin - 5'd12 : bin;
      if (rem == 5'd0)
         res.hour = BCD_12;
      else if (rem >= 5'd10)
         res.hour = {4'd1, 4'(rem - 5'd10)};
      else
         res.hour = {4'd0, rem[3:0]};
      return res;
   endfunction

endpackage

// File: rtl/dem_gio_bcd_if.sv
// Bus between the key-scan / 1 Hz logic and the time-of-day counter, plus the digit outputs.
interface dem_gio_bcd_if;
   logic       clk1hz;
   logic       run;
   logic       inc_min;
   logic       inc_hour;
   logic       clr_sec;
   logic [3:0] sec_l;
   logic [3:0] sec_h;
   logic [3:0] min_l;
   logic [3:0] min_h;
   logic [3:0] hour_l;
   logic [3:0] hour_h;
   logic       tick_sec;
   logic       pm;

   modport master (
      output clk1hz, run, inc_min, inc_hour, clr_sec,
      input  sec_l, sec_h, min_l, min_h, hour_l, hour_h, tick_sec, pm
   );

   modport slave (
      input  clk1hz, run, inc_min, inc_hour, clr_sec,
      output sec_l, sec_h, min_l, min_h, hour_l, hour_h, tick_sec, pm
   );
endinterface

// File: rtl/dem_gio_bcd_mod.sv
// Two-digit BCD modulo counter: counts 00..MAX, clr wins over inc, carry when inc wraps at MAX.
module dem_bcd_mod #(
   parameter logic [7:0] MAX  = 8'h59,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] dig_l,
   output logic [3:0] dig_h,
   output logic       carry
);

   logic [7:0] val;
   logic       at_max;

   assign at_max = (val == MAX);
   assign carry  = inc & ~clr & at_max;
   assign dig_l  = val[3:0];
   assign dig_h  = val[7:4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         val <= INIT;
      else if (clr)
         val <= '0;
      else if (inc) begin
         if (at_max)
            val <= '0;
         else if (val[3:0] == 4'd9)
            val <= {val[7:4] + 4'd1, 4'd0};
         else
            val <= {val[7:4], val[3:0] + 4'd1};
      end
   end

endmodule

// File: rtl/dem_gio_bcd.sv
// BCD hh:mm:ss counter advanced by rising edges of the 1 Hz wave, with set pulses from the keys.
// Optional 12-hour display selected by DEM_GIO_12H_EN.
module dem_gio_bcd
   import dem_gio_bcd_pkg::*;
#(
   parameter logic [7:0] INIT_HH = 8'h12,
   parameter logic [7:0] INIT_MM = 8'h00,
   parameter logic [7:0] INIT_SS = 8'h00
) (
   input logic          clki,
   input logic          rst_n,
   dem_gio_bcd_if.slave bus
);

   logic       clk1hz_q;
   logic       rise;
   logic       adv;
   logic       tick_q;
   logic       sec_carry;
   logic       min_carry;
   logic       min_inc;
   logic       hour_inc;
   logic       unused_hour_carry;
   logic [3:0] hour_l24;
   logic [3:0] hour_h24;

   // clk1hz_q resets high so a wave already high at release is not an edge.
   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         clk1hz_q <= 1'b1;
         tick_q   <= 1'b0;
      end else begin
         clk1hz_q <= bus.clk1hz;
         tick_q   <= adv;
      end
   end

   assign rise = bus.clk1hz & ~clk1hz_q;
   assign adv  = rise & bus.run & ~bus.clr_sec;

   // A set pulse owns its field for the cycle: it gives exactly +1 and
   // the coincident tick carry (and anything it would ripple) is dropped.
   assign min_inc  = bus.inc_min | sec_carry;
   assign hour_inc = bus.inc_hour | (min_carry & ~bus.inc_min);

   dem_bcd_mod #(.MAX(BCD_SEC_MAX), .INIT(INIT_SS)) u_sec (
      .clk(clki), .rst_n(rst_n), .inc(adv), .clr(bus.clr_sec),
      .dig_l(bus.sec_l), .dig_h(bus.sec_h), .carry(sec_carry)
   );

   dem_bcd_mod #(.MAX(BCD_MIN_MAX), .INIT(INIT_MM)) u_min (
      .clk(clki), .rst_n(rst_n), .inc(min_inc), .clr(1'b0),
      .dig_l(bus.min_l), .dig_h(bus.min_h), .carry(min_carry)
   );

   dem_bcd_mod #(.MAX(BCD_HOUR_MAX), .INIT(INIT_HH)) u_hour (
      .clk(clki), .rst_n(rst_n), .inc(hour_inc), .clr(1'b0),
      .dig_l(hour_l24), .dig_h(hour_h24), .carry(unused_hour_carry)
   );

   assign bus.tick_sec = tick_q;

`ifdef DEM_GIO_12H_EN
   hour12_t h12;
   assign h12         = to_12h({hour_h24, hour_l24});
   assign bus.hour_l  = h12.hour[3:0];
   assign bus.hour_h  = h12.hour[7:4];
   assign bus.pm      = h12.pm;
`else
   assign bus.hour_l  = hour_l24;
   assign bus.hour_h  = hour_h24;
   assign bus.pm      = 1'b0;
`endif

endmodule

// File: tb/tb_dem_gio_bcd.sv
// Bench for dem_gio_bcd: directed table, corner sequences and random stimulus against a time model.
module tb_dem_gio_bcd;

   logic clki  = 1'b0;
   logic rst_n = 1'b0;
   always #5 clki = ~clki;

   dem_gio_bcd_if bus_a();
   dem_gio_bcd_if bus_b();

   assign bus_b.clk1hz   = bus_a.clk1hz;
   assign bus_b.run      = bus_a.run;
   assign bus_b.inc_min  = bus_a.inc_min;
   assign bus_b.inc_hour = bus_a.inc_hour;
   assign bus_b.clr_sec  = bus_a.clr_sec;

   dem_gio_bcd dut_a (.clki(clki), .rst_n(rst_n), .bus(bus_a));

   dem_gio_bcd #(.INIT_HH(8'h23), .INIT_MM(8'h59), .INIT_SS(8'h58)) dut_b (
      .clki(clki), .rst_n(rst_n), .bus(bus_b)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // model: index 0 = dut_a, 1 = dut_b; plain integers for h/m/s
   int   mh[2];
   int   mm[2];
   int   ms[2];
   logic m_prev;
   logic m_tick;

   typedef struct {
      logic c, r, im, ih, cs;
      int   eh, em, es;
      logic et;
   } vec_t;

   function automatic logic [23:0] disp(input int h, input int m, input int s);
      int hd;
      hd = h;
`ifdef DEM_GIO_12H_EN
      hd = (h % 12 == 0) ? 12 : h % 12;
`endif
      return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   function automatic logic exp_pm(input int h);
`ifdef DEM_GIO_12H_EN
      return h >= 12;
`else
      return (h < 0);
`endif
   endfunction

   function automatic logic [23:0] digits(input int k);
      if (k == 0)
         return {bus_a.hour_h, bus_a.hour_l, bus_a.min_h, bus_a.min_l, bus_a.sec_h, bus_a.sec_l};
      return {bus_b.hour_h, bus_b.hour_l, bus_b.min_h, bus_b.min_l, bus_b.sec_h, bus_b.sec_l};
   endfunction

   function automatic logic [1:0] tick_pm(input int k);
      if (k == 0) return {bus_a.tick_sec, bus_a.pm};
      return {bus_b.tick_sec, bus_b.pm};
   endfunction

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic compare_all(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_time%0d", tag, k), digits(k), disp(mh[k], mm[k], ms[k]));
         check($sformatf("%s_tickpm%0d", tag, k), 24'(tick_pm(k)), 24'({m_tick, exp_pm(mh[k])}));
      end
   endtask

   task automatic model_reset();
      mh[0] = 12; mm[0] = 0;  ms[0] = 0;
      mh[1] = 23; mm[1] = 59; ms[1] = 58;
      m_prev = 1'b1;
      m_tick = 1'b0;
   endtask

   task automatic model_step(input logic c, r, im, ih, cs);
      logic adv;
      logic car_s, car_m;
      adv = c & ~m_prev & r & ~cs;
      for (int k = 0; k < 2; k++) begin
         car_s = adv && ms[k] == 59;
         car_m = car_s && !im && mm[k] == 59;
         ms[k] = cs ? 0 : (adv ? (ms[k] + 1) % 60 : ms[k]);
         mm[k] = (im || car_s) ? (mm[k] + 1) % 60 : mm[k];
         mh[k] = (ih || car_m) ? (mh[k] + 1) % 24 : mh[k];
      end
      m_prev = c;
      m_tick = adv;
   endtask

   // called just after a falling edge: drive, let one rising edge pass, compare
   task automatic step(input logic c, r, im, ih, cs, input string tag);
      bus_a.clk1hz   = c;
      bus_a.run      = r;
      bus_a.inc_min  = im;
      bus_a.inc_hour = ih;
      bus_a.clr_sec  = cs;
      model_step(c, r, im, ih, cs);
      @(negedge clki);
      compare_all(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clki);
      compare_all("reset");
      rst_n = 1'b1;
   endtask

   vec_t vecs[12];
   logic cur;

   initial begin
      vecs[0]  = '{1, 1, 0, 0, 0, 12, 0, 0, 0};
      vecs[1]  = '{0, 1, 0, 0, 0, 12, 0, 0, 0};
      vecs[2]  = '{1, 1, 0, 0, 0, 12, 0, 1, 1};
      vecs[3]  = '{1, 1, 0, 0, 0, 12, 0, 1, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 12, 0, 1, 0};
      vecs[5]  = '{1, 0, 0, 0, 0, 12, 0, 1, 0};
      vecs[6]  = '{1, 1, 0, 0, 0, 12, 0, 1, 0};
      vecs[7]  = '{0, 1, 1, 0, 0, 12, 1, 1, 0};
      vecs[8]  = '{1, 1, 0, 0, 1, 12, 1, 0, 0};
      vecs[9]  = '{0, 1, 0, 1, 0, 13, 1, 0, 0};
      vecs[10] = '{1, 1, 1, 1, 0, 14, 2, 1, 1};
      vecs[11] = '{0, 1, 0, 0, 0, 14, 2, 1, 0};

      bus_a.clk1hz = 1'b1; bus_a.run = 1'b1;
      bus_a.inc_min = 1'b0; bus_a.inc_hour = 1'b0; bus_a.clr_sec = 1'b0;
      do_reset();

      foreach (vecs[i]) begin
         step(vecs[i].c, vecs[i].r, vecs[i].im, vecs[i].ih, vecs[i].cs, $sformatf("vec%0d", i));
         check($sformatf("tbl_time%0d", i), digits(0), disp(vecs[i].eh, vecs[i].em, vecs[i].es));
         check($sformatf("tbl_tick%0d", i), 24'(bus_a.tick_sec), 24'(vecs[i].et));
      end

      // 23:59:58 -> 23:59:59 -> 00:00:00, tick one cycle wide, one cycle after each edge
      do_reset();
      step(0, 1, 0, 0, 0, "wrap");
      step(1, 1, 0, 0, 0, "wrap");
      check("wrap_59", {digits(1), 24'(bus_b.tick_sec)} , {disp(23, 59, 59), 24'd1});
      step(1, 1, 0, 0, 0, "wrap");
      check("wrap_tick_width", 24'(bus_b.tick_sec), 24'd0);
      step(0, 1, 0, 0, 0, "wrap");
      step(1, 1, 0, 0, 0, "wrap");
      check("wrap_00", {digits(1), 24'(bus_b.tick_sec)}, {disp(0, 0, 0), 24'd1});

      // 10:59:59 with inc_min coincident with the edge: hour carry dropped
      do_reset();
      step(0, 1, 0, 0, 0, "drop");
      step(1, 1, 0, 0, 0, "drop");
      for (int i = 0; i < 11; i++) step(1, 1, 0, 1, 0, "drop");
      check("drop_pre", digits(1), disp(10, 59, 59));
      step(0, 1, 0, 0, 0, "drop");
      step(1, 1, 1, 0, 0, "drop");
      check("drop_carry", digits(1), disp(10, 0, 0));

      // run low across three edges, then exactly one advance
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, "hold");
         step(1, 0, 0, 0, 0, "hold");
      end
      check("hold_time", {digits(1), 24'(bus_b.tick_sec)}, {disp(10, 0, 0), 24'd0});
      step(1, 1, 0, 0, 0, "hold");
      check("hold_no_spurious", 24'(bus_b.tick_sec), 24'd0);
      step(0, 1, 0, 0, 0, "hold");
      step(1, 1, 0, 0, 0, "hold");
      check("hold_resume", digits(1), disp(10, 0, 1));

      // random stimulus against the model
      cur = bus_a.clk1hz;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) cur = ~cur;
         step(cur, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0, "rand");
      end

      // asynchronous reset mid-cycle takes effect without a clock edge
      @(posedge clki);
      #2 rst_n = 1'b0;
      model_reset();
      #1 compare_all("async_rst");
      @(negedge clki);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if ($urandom_range(0, 2) == 0) cur = ~cur;
         step(cur, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
